// File: rtl/qif_pkg.sv
// Shared constants, width helpers and channel-state type for the QIF neuron array.
package qif_pkg;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_W          = 8;
  localparam int DEF_V_TH       = 200;
  localparam int DEF_V_RESET    = 0;
  localparam int DEF_V_REST     = 0;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_REFRAC     = 2;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so out-of-range monitor selects are representable.
  function automatic int sel_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int rcnt_w(input int refrac);
    return (refrac > 0) ? $clog2(refrac + 1) : 1;
  endfunction

  localparam int DEF_RCNT_W = rcnt_w(DEF_REFRAC);

  typedef struct packed {
    logic [DEF_W-1:0]      v;
    logic [DEF_RCNT_W-1:0] rcnt;
  } chan_state_t;

endpackage

// File: rtl/qif_neuron_array_if.sv
// Control/observation bundle of the QIF neuron array: drive side (master) and array side (slave).
interface qif_neuron_array_if
  import qif_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
);

  logic                    en;
  logic [N_CH*W-1:0]       i_syn;
  logic [sel_w(N_CH)-1:0]  mon_sel;
  logic [W-1:0]            v_mon;
  logic [N_CH-1:0]         spike;
  logic                    frame_done;

  modport master (
    output en, i_syn, mon_sel,
    input  v_mon, spike, frame_done
  );

  modport slave (
    input  en, i_syn, mon_sel,
    output v_mon, spike, frame_done
  );

endinterface

// File: rtl/qif_update.sv
// Combinational single-channel QIF step: refractory hold, quadratic growth, leak, threshold.
module qif_update
  import qif_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int V_TH       = DEF_V_TH,
  parameter int V_RESET    = DEF_V_RESET,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC,
  parameter int RCNT_W     = rcnt_w(DEF_REFRAC)
) (
  input  logic [W-1:0]      v,
  input  logic [RCNT_W-1:0] rcnt,
  input  logic [W-1:0]      i_syn,
  output logic [W-1:0]      v_next,
  output logic [RCNT_W-1:0] rcnt_next,
  output logic              fire
);

  localparam int SUM_W = W + 2;

  // Full-precision square, keeping only the upper half (v*v / 2^W).
  function automatic logic [W-1:0] square_hi(input logic [W-1:0] x);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, x};
    return prod[2*W-1:W];
  endfunction

  logic [W-1:0]     sq;
  logic [W-1:0]     leak;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sq        = square_hi(v);
    leak      = v >> LEAK_SHIFT;
    // leak <= v, so the subtraction cannot wrap below zero.
    sum       = {2'b00, v} + {2'b00, sq} + {2'b00, i_syn} - {2'b00, leak};
    fire      = 1'b0;
    v_next    = sum[W-1:0];
    rcnt_next = rcnt;
    if (rcnt != '0) begin
      v_next    = W'(V_RESET);
      rcnt_next = rcnt - RCNT_W'(1);
    end else if (sum >= SUM_W'(V_TH)) begin
      fire      = 1'b1;
      v_next    = W'(V_RESET);
      rcnt_next = RCNT_W'(REFRAC);
    end
  end

endmodule

// File: rtl/qif_neuron_array.sv
// Time-multiplexed QIF neuron array: one shared update path visits channels round-robin.
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int W          = DEF_W,
  parameter int V_TH       = DEF_V_TH,
  parameter int V_RESET    = DEF_V_RESET,
  parameter int V_REST     = DEF_V_REST,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC
) (
  input  logic              clk,
  input  logic              rst,
  qif_neuron_array_if.slave bus
);

  localparam int PTR_W  = ptr_w(N_CH);
  localparam int SEL_W  = sel_w(N_CH);
  localparam int RCNT_W = rcnt_w(REFRAC);

  typedef struct packed {
    logic [W-1:0]      v;
    logic [RCNT_W-1:0] rcnt;
  } ch_state_t;

  ch_state_t         st [N_CH];
  logic [PTR_W-1:0]  ptr_p0;
  ch_state_t         cur;
  logic [W-1:0]      i_cur;
  logic [W-1:0]      v_next;
  logic [RCNT_W-1:0] rcnt_next;
  logic              fire;
  logic [W-1:0]      mon_v;
  logic              last_ch;

  logic [N_CH-1:0]   spike_p1;
  logic              frame_done_p1;
  logic [W-1:0]      v_mon_p1;

  always_comb begin
    cur     = st[ptr_p0];
    i_cur   = bus.i_syn[ptr_p0*W +: W];
    last_ch = (ptr_p0 == PTR_W'(N_CH - 1));
    mon_v   = '0;
    if (bus.mon_sel < SEL_W'(N_CH))
      mon_v = st[bus.mon_sel[PTR_W-1:0]].v;
  end

  qif_update #(
    .W          (W),
    .V_TH       (V_TH),
    .V_RESET    (V_RESET),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .RCNT_W     (RCNT_W)
  ) u_update (
    .v         (cur.v),
    .rcnt      (cur.rcnt),
    .i_syn     (i_cur),
    .v_next    (v_next),
    .rcnt_next (rcnt_next),
    .fire      (fire)
  );

  // Stage p0: channel state and scan pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0 <= '0;
      for (int k = 0; k < N_CH; k++)
        st[k] <= '{v: W'(V_REST), rcnt: '0};
    end else if (bus.en) begin
      st[ptr_p0] <= '{v: v_next, rcnt: rcnt_next};
      ptr_p0     <= last_ch ? '0 : ptr_p0 + PTR_W'(1);
    end
  end

  // Stage p1: registered spike, frame and monitor outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_p1      <= '0;
      frame_done_p1 <= 1'b0;
      v_mon_p1      <= '0;
    end else begin
      spike_p1      <= '0;
      frame_done_p1 <= 1'b0;
      if (bus.en) begin
        spike_p1[ptr_p0] <= fire;
        frame_done_p1    <= last_ch;
      end
      v_mon_p1 <= mon_v;
    end
  end

  assign bus.spike      = spike_p1;
  assign bus.frame_done = frame_done_p1;
  assign bus.v_mon      = v_mon_p1;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed bench for qif_neuron_array: reference model feeds a scoreboard checked every cycle.
module tb_qif_neuron_array;
  import qif_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int VT = 200;
  localparam int LS = 3;
  localparam int RF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qif_neuron_array_if #(.N_CH(N), .W(W)) bus ();

  qif_neuron_array #(
    .N_CH(N), .W(W), .V_TH(VT), .V_RESET(0), .V_REST(0),
    .LEAK_SHIFT(LS), .REFRAC(RF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int v_mon;
    int spike;
    int frame_done;
  } exp_t;

  exp_t sb[$];
  int   mv[N];
  int   mr[N];
  int   mp;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int i_of(input int k);
    logic [W-1:0] x;
    x = bus.i_syn[k*W +: W];
    return int'(x);
  endfunction

  task automatic set_i(input int c0, input int c1, input int c2, input int c3);
    bus.i_syn = {W'(c3), W'(c2), W'(c1), W'(c0)};
  endtask

  // Predict the outputs after the coming edge, advance the model, then compare.
  task automatic step();
    exp_t e;
    exp_t got;
    int   sel;
    int   p;
    int   sq;
    int   lk;
    int   sum;
    e   = '{0, 0, 0};
    sel = int'(bus.mon_sel);
    if (rst) begin
      mp = 0;
      for (int k = 0; k < N; k++) begin
        mv[k] = 0;
        mr[k] = 0;
      end
    end else begin
      e.v_mon = (sel < N) ? mv[sel] : 0;
      if (bus.en) begin
        p = mp;
        if (mr[p] > 0) begin
          mv[p] = 0;
          mr[p] = mr[p] - 1;
        end else begin
          sq  = (mv[p] * mv[p]) / (1 << W);
          lk  = mv[p] / (1 << LS);
          sum = mv[p] + sq + i_of(p) - lk;
          if (sum >= VT) begin
            e.spike = 1 << p;
            mv[p]   = 0;
            mr[p]   = RF;
          end else begin
            mv[p] = sum;
          end
        end
        e.frame_done = (p == N - 1) ? 1 : 0;
        mp = (mp + 1) % N;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("v_mon", 32'(bus.v_mon), got.v_mon);
    chk("spike", 32'(bus.spike), got.spike);
    chk("frame_done", 32'(bus.frame_done), got.frame_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    bus.en = 1'b0;
    run(n);
    rst    = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.i_syn   = '0;
    bus.mon_sel = '0;

    // Reset, then idle inputs: membrane stays 0, frame pulses every 4 cycles
    do_reset(2);
    bus.en = 1'b1;
    run(3);
    chk("fd_before_first", 32'(bus.frame_done), 0);
    run(1);
    chk("fd_first", 32'(bus.frame_done), 1);
    run(96);

    // Integration to spike, then refractory hold and recovery
    do_reset(1);
    set_i(50, 0, 0, 0);
    bus.mon_sel = 0;
    bus.en      = 1'b1;
    run(2);
    chk("int_v1", 32'(bus.v_mon), 50);
    run(4);
    chk("int_v2", 32'(bus.v_mon), 103);
    run(4);
    chk("int_v3", 32'(bus.v_mon), 182);
    run(3);
    chk("spike_ch0", 32'(bus.spike), 1);
    run(1);
    chk("v_after_spike", 32'(bus.v_mon), 0);
    chk("spike_one_cycle", 32'(bus.spike), 0);
    run(12);
    chk("v_after_refrac", 32'(bus.v_mon), 50);
    run(24);

    // Enable gating: hold for 7 cycles, resume at the same channel
    do_reset(1);
    set_i(50, 0, 0, 0);
    bus.en = 1'b1;
    run(5);
    bus.en = 1'b0;
    run(7);
    chk("gated_hold", 32'(bus.v_mon), 103);
    bus.en = 1'b1;
    run(5);
    chk("gated_resume", 32'(bus.v_mon), 182);

    // Reset mid-operation with en still high
    do_reset(1);
    bus.en = 1'b1;
    run(10);
    chk("pre_mid_reset", 32'(bus.v_mon), 182);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("mid_reset_vmon", 32'(bus.v_mon), 0);
    run(2);
    chk("post_mid_reset", 32'(bus.v_mon), 50);

    // Monitor select: out of range reads 0, switching follows one cycle later
    do_reset(1);
    set_i(50, 30, 0, 0);
    bus.mon_sel = 3'd4;
    bus.en      = 1'b1;
    run(3);
    chk("mon_oob", 32'(bus.v_mon), 0);
    bus.mon_sel = 3'd1;
    run(1);
    chk("mon_sel1", 32'(bus.v_mon), 30);
    bus.mon_sel = 3'd0;
    run(1);
    chk("mon_sel0", 32'(bus.v_mon), 50);

    // Mixed traffic with random inputs, enables and monitor selects
    for (int i = 0; i < 200; i++) begin
      bus.en      = ($urandom_range(0, 3) != 0);
      bus.mon_sel = 3'($urandom_range(0, 7));
      if ((i % 16) == 0)
        set_i($urandom_range(0, 255), $urandom_range(0, 80),
              $urandom_range(0, 120), $urandom_range(0, 20));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qif_neuron_array.md
# qif_neuron_array

Parametrised, time-multiplexed array of quadratic integrate-and-fire (QIF) neurons. It generalises the single fixed 8-bit QIF neuron to N_CH channels of configurable width, adding leak, refractory period, per-channel spike outputs and a monitor port. One shared update datapath visits channels round-robin, one channel per enabled cycle. It sits directly under the tile top level, fed by the input switches and driving the display/bidirectional pins.

## Interface
- N_CH, 4: number of neuron channels (≥1)
- W, 8: membrane/input width in bits
- V_TH, 200: spike threshold, ≤ 2^W−1
- V_RESET, 0: membrane value after a spike
- V_REST, 0: membrane value after reset
- LEAK_SHIFT, 3: leak = V >> LEAK_SHIFT
- REFRAC, 2: number of channel updates held after a spike (0 = none)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  advance scan and update when high
- i_syn  in  N_CH*W  synaptic input; channel k is bits [k*W +: W]
- mon_sel  in  $clog2(N_CH)+1  channel shown on v_mon
- v_mon  out  W  registered membrane of channel mon_sel
- spike  out  N_CH  one-cycle spike pulse per channel
- frame_done  out  1  pulse after channel N_CH−1 updates

## Operation
- Per-channel state: v[k] (W bits), rcnt[k] (refractory count). Scan pointer ptr counts 0..N_CH−1 and wraps to 0.
- Each cycle with en=1, channel p=ptr updates:
  - rcnt[p]≠0: v[p]←V_RESET, rcnt[p]−−, i_syn ignored, no spike.
  - Otherwise:
    - sq = (v·v)>>W, computed at 2W bits, upper W kept.
    - leak = v>>LEAK_SHIFT.
    - sum = v + sq + I − leak, held in W+2 bits. The result is never negative because leak ≤ v.
    - If sum ≥ V_TH: spike; v[p]←V_RESET, rcnt[p]←REFRAC.
    - Else: v[p]←sum[W−1:0]. This never truncates, since sum < V_TH ≤ 2^W−1.
  - ptr advances.
- en=0: ptr, v, rcnt hold; spike and frame_done are 0.
- mon_sel ≥ N_CH: v_mon=0.
- Only one channel is written per cycle, so no write conflicts exist.

## Timing
- Reset (rst=1 at an edge):
  - ptr=0, all v=V_REST, all rcnt=0.
  - spike=0, frame_done=0, v_mon=0.
  - Applies mid-frame as well; the in-flight update is discarded.
- Update of channel p in cycle t (en=1, ptr=p): v[p] and rcnt[p] change at the edge ending cycle t.
- spike[p] is high during cycle t+1 only.
- frame_done is high during cycle t+1 when p=N_CH−1.
- v_mon registers v[mon_sel] each cycle, so it shows state one cycle after the write (latency 1 from a v change or a mon_sel change).
- Each channel updates every N_CH enabled cycles. Each refractory interval spans REFRAC of that channel's own updates.
- rst has priority over en.

## Structure
- Package qif_pkg:
  - default parameter constants
  - function clog2-based width helpers
  - typedef struct for per-channel state {v, rcnt}
- Sub-module qif_update (combinational): takes v, rcnt, I; returns v_next, rcnt_next, fire.
- The top level holds the state arrays, scan counter and output registers.
- Expected size: ~150–250 lines.

## Test plan
All scenarios use the defaults (N_CH=4, W=8, V_TH=200, V_RESET=V_REST=0, LEAK_SHIFT=3, REFRAC=2).
1. Reset: rst=1 for 2 cycles, then en=1, i_syn=0 for 100 cycles → v_mon=0 throughout; spike=0; frame_done pulses every 4th cycle (first in cycle 4 after en).
2. Integration and spike: i_syn ch0=50, others=0, mon_sel=0, en=1:
   - v_mon sequence over ch0 updates is 50, 103, 182.
   - Update 4 gives sum=339 → spike[0] pulses one cycle after that update; v[0]=0.
   - Other spike bits stay 0.
3. Refractory: continue scenario 2 → the next 2 ch0 updates keep v=0 despite I=50; the 3rd update gives v=50; the spike period is 6 ch0 updates.
4. en gating: same as scenario 2, but drop en for 7 cycles after update 2 → v_mon holds 103; no spikes; ptr resumes at the same channel.
5. Reset mid-operation: rst=1 for one cycle after ch0 reaches 182 with rcnt=0 → v=0, ptr=0; the next ch0 update gives 50.
6. Monitor boundary: mon_sel=4 → v_mon=0. Switching mon_sel from 0 to 1 mid-run gives v[1] one cycle later.
